// File: rtl/risc_v_mike_pkg.sv
// Shared types and constants for the risc_v_mike instruction-memory slice.
package risc_v_mike_pkg;

  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

  typedef logic [31:0] t_pc_addr;

  typedef enum logic [1:0] {
    IMEM_CLEAR,
    IMEM_RUN,
    IMEM_LOAD
  } t_imem_state;

  // What the fetch data output presents: reset zero, forced NOP, or RAM word
  typedef enum logic [1:0] {
    FSEL_ZERO,
    FSEL_NOP,
    FSEL_RAM
  } t_fetch_sel;

endpackage

// File: rtl/risc_v_mike_imem_sram_sp.sv
// Single-port synchronous RAM; read data is registered and holds while idle or writing.
module risc_v_mike_imem_sram_sp #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024,
  parameter int AW     = 10
) (
  input  logic              clk,
  input  logic              en_i,
  input  logic              we_i,
  input  logic [AW-1:0]     addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (en_i) begin
      if (we_i) begin
        mem_q[addr_i] <= wdata_i;
      end else begin
        rdata_o <= mem_q[addr_i];
      end
    end
  end

endmodule

// File: rtl/risc_v_mike_loadable_instr_mem.sv
// Instruction memory with NOP clear after reset, runtime program load and a
// registered fetch port that flags misaligned or out-of-range addresses.
module risc_v_mike_loadable_instr_mem
  import risc_v_mike_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_valid,
  output logic [DATA_W-1:0] fetch_data,
  output logic              fetch_err,
  input  logic              load_start,
  input  logic [CNT_W-1:0]  load_len,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  output logic              load_ready,
  output logic              load_done,
  output logic              core_hold
);

  localparam int                RAM_AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]  LAST_C  = CNT_W'(DEPTH - 1);
  localparam logic [ADDR_W-2:0] DEPTH_A = (ADDR_W - 1)'(DEPTH);

  t_imem_state       state_q;
  t_fetch_sel        fsel_q;
  logic [CNT_W-1:0]  cnt_q, len_q, cnt_inc, len_clamp;
  logic              fvalid_q, ferr_q, load_ready_q, load_done_q, core_hold_q;

  logic [ADDR_W-3:0] fidx;
  logic              fetch_go, fetch_bad, load_acc;
  logic              ram_en, ram_we;
  logic [RAM_AW-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata, ram_rdata;

  assign fidx      = fetch_addr[ADDR_W-1:2];
  // Range check at full index width so huge addresses never alias low words
  assign fetch_bad = (fetch_addr[1:0] != 2'b00) || ({1'b0, fidx} >= DEPTH_A);
  assign fetch_go  = (state_q == IMEM_RUN) && fetch_req;
  assign load_acc  = (state_q == IMEM_LOAD) && load_valid && load_ready_q;
  assign cnt_inc   = cnt_q + 1'b1;
  assign len_clamp = (load_len > DEPTH_C) ? DEPTH_C : load_len;

  always_comb begin
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = cnt_q[RAM_AW-1:0];
    ram_wdata = load_data;
    case (state_q)
      IMEM_CLEAR: begin
        ram_en    = 1'b1;
        ram_we    = 1'b1;
        ram_wdata = DATA_W'(INSTR_NOP);
      end
      IMEM_LOAD: begin
        ram_en = load_acc;
        ram_we = load_acc;
      end
      default: begin
        ram_en   = fetch_go && !fetch_bad;
        ram_addr = fidx[RAM_AW-1:0];
      end
    endcase
  end

  risc_v_mike_imem_sram_sp #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (RAM_AW)
  ) u_sram (
    .clk     (clk),
    .en_i    (ram_en),
    .we_i    (ram_we),
    .addr_i  (ram_addr),
    .wdata_i (ram_wdata),
    .rdata_o (ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IMEM_CLEAR;
      cnt_q        <= '0;
      len_q        <= '0;
      fsel_q       <= FSEL_ZERO;
      fvalid_q     <= 1'b0;
      ferr_q       <= 1'b0;
      load_ready_q <= 1'b0;
      load_done_q  <= 1'b0;
      core_hold_q  <= 1'b1;
    end else begin
      fvalid_q    <= 1'b0;
      ferr_q      <= 1'b0;
      load_done_q <= 1'b0;
      case (state_q)
        IMEM_CLEAR: begin
          if (cnt_q == LAST_C) begin
            state_q     <= IMEM_RUN;
            cnt_q       <= '0;
            core_hold_q <= 1'b0;
          end else begin
            cnt_q <= cnt_inc;
          end
        end
        IMEM_LOAD: begin
          // cnt_q only equals len_q here for a zero-length load
          if (cnt_q == len_q) begin
            state_q     <= IMEM_RUN;
            load_done_q <= 1'b1;
            core_hold_q <= 1'b0;
          end else if (load_acc) begin
            cnt_q <= cnt_inc;
            if (cnt_inc == len_q) begin
              state_q      <= IMEM_RUN;
              load_done_q  <= 1'b1;
              load_ready_q <= 1'b0;
              core_hold_q  <= 1'b0;
            end
          end
        end
        default: begin
          if (fetch_req) begin
            fvalid_q <= 1'b1;
            ferr_q   <= fetch_bad;
            fsel_q   <= fetch_bad ? FSEL_NOP : FSEL_RAM;
          end
          if (load_start) begin
            state_q      <= IMEM_LOAD;
            len_q        <= len_clamp;
            cnt_q        <= '0;
            load_ready_q <= (len_clamp != '0);
            core_hold_q  <= 1'b1;
          end
        end
      endcase
    end
  end

  assign fetch_valid = fvalid_q;
  assign fetch_err   = ferr_q;
  assign fetch_data  = (fsel_q == FSEL_RAM) ? ram_rdata :
                       (fsel_q == FSEL_NOP) ? DATA_W'(INSTR_NOP) : '0;
  assign load_ready  = load_ready_q;
  assign load_done   = load_done_q;
  assign core_hold   = core_hold_q;

endmodule

// File: tb/tb_risc_v_mike_loadable_instr_mem.sv
// Randomised bench for the loadable instruction memory against a word-array reference model.
module tb_risc_v_mike_loadable_instr_mem;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 40;
  localparam int CNT_W  = $clog2(DEPTH) + 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              fetch_req = 1'b0;
  logic [ADDR_W-1:0] fetch_addr = '0;
  logic              fetch_valid;
  logic [DATA_W-1:0] fetch_data;
  logic              fetch_err;
  logic              load_start = 1'b0;
  logic [CNT_W-1:0]  load_len = '0;
  logic              load_valid = 1'b0;
  logic [DATA_W-1:0] load_data = '0;
  logic              load_ready;
  logic              load_done;
  logic              core_hold;

  risc_v_mike_loadable_instr_mem #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .CNT_W  (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .fetch_req   (fetch_req),
    .fetch_addr  (fetch_addr),
    .fetch_valid (fetch_valid),
    .fetch_data  (fetch_data),
    .fetch_err   (fetch_err),
    .load_start  (load_start),
    .load_len    (load_len),
    .load_valid  (load_valid),
    .load_data   (load_data),
    .load_ready  (load_ready),
    .load_done   (load_done),
    .core_hold   (core_hold)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: the memory as a plain array plus a few counters
  logic [31:0] m_mem [DEPTH];
  int          clear_left = 0;
  bit          in_load = 0;
  int          load_left = 0;
  int          load_idx = 0;
  bit          e_valid = 0, e_err = 0, e_ready = 0, e_done = 0, e_hold = 1;
  logic [31:0] e_data = '0;
  bit          chk_en = 0;

  always @(posedge clk) begin
    bit          was_ready;
    logic [31:0] idx;
    was_ready = e_ready;
    if (!rst) begin
      foreach (m_mem[i]) m_mem[i] = NOP;
      clear_left = DEPTH;
      in_load = 0; load_left = 0; load_idx = 0;
      e_valid = 0; e_err = 0; e_ready = 0; e_done = 0; e_hold = 1; e_data = '0;
      chk_en = 1;
    end else begin
      e_valid = 0; e_err = 0; e_done = 0;
      if (clear_left > 0) begin
        clear_left--;
        e_hold = (clear_left > 0);
      end else if (in_load) begin
        if (load_left == 0) begin
          in_load = 0; e_done = 1; e_hold = 0;
        end else if (load_valid && was_ready) begin
          m_mem[load_idx] = load_data;
          load_idx++;
          load_left--;
          if (load_left == 0) begin
            in_load = 0; e_done = 1; e_ready = 0; e_hold = 0;
          end
        end
      end else begin
        if (fetch_req) begin
          idx     = fetch_addr >> 2;
          e_valid = 1;
          e_err   = (fetch_addr % 4 != 0) || (idx >= DEPTH);
          e_data  = e_err ? NOP : m_mem[idx];
        end
        if (load_start) begin
          load_left = (load_len > DEPTH) ? DEPTH : int'(load_len);
          load_idx  = 0;
          in_load   = 1;
          e_hold    = 1;
          e_ready   = (load_left > 0);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("fetch_valid", 32'(fetch_valid), 32'(e_valid));
      check("fetch_err",   32'(fetch_err),   32'(e_err));
      check("fetch_data",  fetch_data,       e_data);
      check("load_ready",  32'(load_ready),  32'(e_ready));
      check("load_done",   32'(load_done),   32'(e_done));
      check("core_hold",   32'(core_hold),   32'(e_hold));
    end
  end

  task automatic idle();
    fetch_req  = 1'b0;
    load_start = 1'b0;
    load_valid = 1'b0;
  endtask

  task automatic fetch_lit(input logic [31:0] a, input logic [31:0] exp_d,
                           input bit exp_e, input string nm);
    fetch_req  = 1'b1;
    fetch_addr = a;
    @(negedge clk);
    fetch_req = 1'b0;
    check({nm, "_valid"}, 32'(fetch_valid), 32'd1);
    check({nm, "_err"},   32'(fetch_err),   32'(exp_e));
    check({nm, "_data"},  fetch_data,       exp_d);
  endtask

  task automatic do_load(input int len, input logic [31:0] w[$], input bit gaps,
                         input bit noise, output int acc, output int cyc,
                         output bit seen_ready);
    int n;
    bit r;
    n = 0; acc = 0; seen_ready = 0;
    load_start = 1'b1;
    load_len   = CNT_W'(len);
    if (noise) begin
      fetch_req  = 1'b1;
      fetch_addr = 32'($urandom_range(0, DEPTH - 1)) << 2;
    end
    @(negedge clk);
    load_start = 1'b0;
    fetch_req  = 1'b0;
    while (!load_done && n < 4 * DEPTH + 40) begin
      r = load_ready;
      if (r) seen_ready = 1;
      load_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      load_data  = (acc < w.size()) ? w[acc] : $urandom;
      if (noise) begin
        fetch_req  = $urandom_range(0, 1) == 1;
        fetch_addr = $urandom;
        load_start = $urandom_range(0, 3) == 0;
        load_len   = CNT_W'($urandom);
      end
      @(negedge clk);
      n++;
      if (load_valid && r) acc++;
    end
    idle();
    cyc = n;
    total++;
    if (!load_done) begin
      bad++;
      $display("FAIL load_timeout: load_done=0 after %0d cycles, expected 1", n);
    end
  endtask

  task automatic wait_clear(input string nm, input bit noise);
    int n;
    n = 0;
    while (core_hold && n < DEPTH + 10) begin
      if (noise) begin
        fetch_req  = $urandom_range(0, 1) == 1;
        fetch_addr = 32'($urandom_range(0, DEPTH - 1)) << 2;
        load_start = $urandom_range(0, 3) == 0;
      end
      n++;
      @(negedge clk);
    end
    idle();
    check(nm, 32'(n), 32'(DEPTH));
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] q[$];
    logic [31:0] none[$];
    int acc, cyc, sel;
    bit sr;

    idle();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_fetch_valid", 32'(fetch_valid), 32'd0);
    check("rst_fetch_data",  fetch_data,       32'd0);
    check("rst_fetch_err",   32'(fetch_err),   32'd0);
    check("rst_load_ready",  32'(load_ready),  32'd0);
    check("rst_load_done",   32'(load_done),   32'd0);
    check("rst_core_hold",   32'(core_hold),   32'd1);
    rst = 1'b1;
    wait_clear("clear_hold_cycles", 1'b1);

    fetch_lit(32'h0, NOP, 1'b0, "f_first");
    fetch_lit(32'(DEPTH * 4 - 4), NOP, 1'b0, "f_last");

    q = '{32'hffff0437, 32'h7ffff137, 32'hffc10113};
    do_load(3, q, 1'b1, 1'b0, acc, cyc, sr);
    check("load3_accepts", 32'(acc), 32'd3);
    fetch_lit(32'h0, 32'hffff0437, 1'b0, "f_w0");
    fetch_lit(32'h4, 32'h7ffff137, 1'b0, "f_w1");
    fetch_lit(32'h8, 32'hffc10113, 1'b0, "f_w2");
    fetch_lit(32'hC, NOP,          1'b0, "f_w3");

    fetch_lit(32'h2,            NOP, 1'b1, "f_misalign");
    fetch_lit(32'(DEPTH * 4),   NOP, 1'b1, "f_depth");
    fetch_lit(32'hFFFF_FFFC,    NOP, 1'b1, "f_top");

    do_load(0, none, 1'b0, 1'b0, acc, cyc, sr);
    check("len0_cycles", 32'(cyc), 32'd1);
    check("len0_ready",  32'(sr),  32'd0);
    fetch_lit(32'h0, 32'hffff0437, 1'b0, "f_len0_kept");

    q.delete();
    for (int i = 0; i < DEPTH + 5; i++) q.push_back($urandom);
    do_load(DEPTH + 5, q, 1'b1, 1'b1, acc, cyc, sr);
    check("clamp_accepts", 32'(acc), 32'(DEPTH));
    check("clamp_ready_after", 32'(load_ready), 32'd0);
    fetch_lit(32'(DEPTH * 4 - 4), q[DEPTH-1], 1'b0, "f_clamp_last");

    for (int it = 0; it < 400; it++) begin
      sel = $urandom_range(0, 9);
      if (sel < 8) begin
        case ($urandom_range(0, 7))
          0:       fetch_addr = $urandom;
          1:       fetch_addr = (32'($urandom_range(0, DEPTH - 1)) << 2) | 32'($urandom_range(1, 3));
          2:       fetch_addr = 32'($urandom_range(DEPTH, DEPTH + 3)) << 2;
          default: fetch_addr = 32'($urandom_range(0, DEPTH - 1)) << 2;
        endcase
        fetch_req = $urandom_range(0, 3) != 0;
        @(negedge clk);
        fetch_req = 1'b0;
      end else begin
        do_load($urandom_range(0, 8), none, 1'b1, 1'b1, acc, cyc, sr);
      end
    end

    load_start = 1'b1;
    load_len   = CNT_W'(4);
    @(negedge clk);
    load_start = 1'b0;
    load_valid = 1'b1;
    load_data  = 32'h1234_5678;
    @(negedge clk);
    load_data  = 32'h9abc_def0;
    @(negedge clk);
    load_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    check("midload_rst_hold", 32'(core_hold), 32'd1);
    rst = 1'b1;
    wait_clear("reclear_hold_cycles", 1'b1);
    fetch_lit(32'h0, NOP, 1'b0, "f_after_reclear0");
    fetch_lit(32'h4, NOP, 1'b0, "f_after_reclear1");
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
